// File: rtl/micro_seq_pkg.sv
// Shared definitions for the microprogram sequencer: sequencing opcodes,
// default vector addresses and microinstruction field layout helpers.
package micro_seq_pkg;

  typedef enum logic [2:0] {
    SEQ_FETCH    = 3'd0,
    SEQ_NEXT     = 3'd1,
    SEQ_DISPATCH = 3'd2,
    SEQ_JUMP     = 3'd3,
    SEQ_CBRANCH  = 3'd4,
    SEQ_CALL     = 3'd5,
    SEQ_RET      = 3'd6,
    SEQ_WAIT     = 3'd7
  } seq_op_e;

  localparam int unsigned SEQ_W            = 3;
  localparam int unsigned EXC_BASE_DEFAULT = 28;
  localparam int unsigned ERR_ADDR_DEFAULT = 31;

  // Width of the condition-select field; never narrower than one bit.
  function automatic int unsigned cselWidth(input int unsigned nCond);
    return (nCond > 1) ? $clog2(nCond) : 1;
  endfunction

  // uinst layout, MSB to LSB: ctrl, seq, csel, target.
  function automatic int unsigned targetLsb();
    return 0;
  endfunction

  function automatic int unsigned cselLsb(input int unsigned uaddrW);
    return uaddrW;
  endfunction

  function automatic int unsigned seqLsb(input int unsigned uaddrW, input int unsigned cselW);
    return uaddrW + cselW;
  endfunction

  function automatic int unsigned ctrlLsb(input int unsigned uaddrW, input int unsigned cselW);
    return uaddrW + cselW + SEQ_W;
  endfunction

  function automatic int unsigned uinstWidth(input int unsigned cwW, input int unsigned uaddrW,
                                             input int unsigned cselW);
    return cwW + SEQ_W + cselW + uaddrW;
  endfunction

endpackage

// File: rtl/micro_sequencer_stack.sv
// Micro-call return-address LIFO. Flush has priority over push/pop; a push
// into a full stack or a pop from an empty one is ignored.
module micro_stack #(
  parameter  int unsigned WIDTH   = 5,
  parameter  int unsigned DEPTH   = 2,
  localparam int unsigned DEPTH_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   dout,
  output logic               full,
  output logic               empty,
  output logic [DEPTH_W-1:0] depth
);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH_W-1:0] count;

  assign full  = (32'(count) == DEPTH);
  assign empty = (count == '0);
  assign depth = count;

  // Present the top-of-stack entry; zero when empty.
  always_comb begin
    dout = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (32'(count) == k + 1) dout = mem[k];
    end
  end

  // Update occupancy and write the pushed entry into the next free slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (push && !full) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (32'(count) == k) mem[k] <= din;
      end
      count <= count + DEPTH_W'(1);
    end else if (pop && !empty) begin
      count <= count - DEPTH_W'(1);
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: selects the next microaddress from the current
// microinstruction, dispatch tables, condition inputs, the return stack and
// exception requests, and gates the datapath control word.
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter  int unsigned CW_W        = 30,
  parameter  int unsigned UADDR_W     = 5,
  parameter  int unsigned N_DISPATCH  = 3,
  parameter  int unsigned N_COND      = 4,
  parameter  int unsigned N_EXC       = 2,
  parameter  int unsigned STACK_DEPTH = 2,
  parameter  int unsigned EXC_BASE    = EXC_BASE_DEFAULT,
  parameter  int unsigned ERR_ADDR    = ERR_ADDR_DEFAULT,
  localparam int unsigned CSEL_W      = cselWidth(N_COND),
  localparam int unsigned UI_W        = uinstWidth(CW_W, UADDR_W, CSEL_W),
  localparam int unsigned DEPTH_W     = $clog2(STACK_DEPTH + 1),
  localparam int unsigned CAUSE_W     = (N_EXC > 1) ? $clog2(N_EXC) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic [UI_W-1:0]               uinst,
  input  logic [N_DISPATCH*UADDR_W-1:0] dispatch_addr,
  input  logic [N_COND-1:0]             cond,
  input  logic [N_EXC-1:0]              exc_req,
  output logic [UADDR_W-1:0]            upc,
  output logic [CW_W-1:0]               ctrl,
  output logic [2:0]                    seq_op,
  output logic [DEPTH_W-1:0]            stack_depth,
  output logic                          exc_taken,
  output logic [CAUSE_W-1:0]            exc_cause,
  output logic                          seq_err
);

  localparam int unsigned TGT_LSB   = targetLsb();
  localparam int unsigned CSEL_LSB  = cselLsb(UADDR_W);
  localparam int unsigned SEQ_LSB   = seqLsb(UADDR_W, CSEL_W);
  localparam int unsigned CTRL_LSB  = ctrlLsb(UADDR_W, CSEL_W);
  localparam int unsigned DISP_MASK = (1 << $clog2(N_DISPATCH)) - 1;

  logic [UADDR_W-1:0] target;
  logic [CSEL_W-1:0]  csel;
  seq_op_e            op;
  logic               condBit;
  int unsigned        dispIdx;
  logic               dispBad;
  logic [UADDR_W-1:0] dispTarget;
  logic               excAny;
  logic [CAUSE_W-1:0] excIdx;
  logic [UADDR_W-1:0] upcInc;
  logic               atTop;
  logic [UADDR_W-1:0] nextUpc;
  logic               seqFault;
  logic               doPush;
  logic               doPop;
  logic [UADDR_W-1:0] stackTop;
  logic               stackFull;
  logic               stackEmpty;
  logic               advance;

  assign target = uinst[TGT_LSB +: UADDR_W];
  assign csel   = uinst[CSEL_LSB +: CSEL_W];
  assign seq_op = uinst[SEQ_LSB +: SEQ_W];
  assign op     = seq_op_e'(seq_op);
  assign ctrl   = (rst || stall) ? '0 : uinst[CTRL_LSB +: CW_W];

  // Selected condition; out-of-range selects read as 0.
  always_comb begin
    condBit = 1'b0;
    if (32'(csel) < N_COND) condBit = cond[csel];
  end

  // Dispatch-table mux, indexed by the low target bits; unpopulated slots are errors.
  always_comb begin
    dispIdx    = 32'(target) & DISP_MASK;
    dispBad    = 1'b1;
    dispTarget = '0;
    for (int unsigned k = 0; k < N_DISPATCH; k++) begin
      if (dispIdx == k) begin
        dispBad    = 1'b0;
        dispTarget = dispatch_addr[k*UADDR_W +: UADDR_W];
      end
    end
  end

  // Lowest-numbered pending exception request wins (scan downwards, last hit kept).
  always_comb begin
    excAny = |exc_req;
    excIdx = '0;
    for (int unsigned i = N_EXC; i > 0; i--) begin
      if (exc_req[i-1]) excIdx = CAUSE_W'(i - 1);
    end
  end

  // Next-address decode for the current seq op, folding sequencing faults into ERR_ADDR.
  always_comb begin
    upcInc   = upc + UADDR_W'(1);
    atTop    = &upc;
    nextUpc  = upc;
    seqFault = 1'b0;
    doPush   = 1'b0;
    doPop    = 1'b0;
    case (op)
      SEQ_FETCH:    nextUpc = '0;
      SEQ_NEXT:     if (atTop) seqFault = 1'b1; else nextUpc = upcInc;
      SEQ_DISPATCH: if (dispBad) seqFault = 1'b1; else nextUpc = dispTarget;
      SEQ_JUMP:     nextUpc = target;
      SEQ_CBRANCH: begin
        if (condBit)    nextUpc = target;
        else if (atTop) seqFault = 1'b1;
        else            nextUpc = upcInc;
      end
      SEQ_CALL: begin
        if (stackFull) seqFault = 1'b1;
        else begin
          doPush  = 1'b1;
          nextUpc = target;
        end
      end
      SEQ_RET: begin
        if (stackEmpty) seqFault = 1'b1;
        else begin
          doPop   = 1'b1;
          nextUpc = stackTop;
        end
      end
      SEQ_WAIT: begin
        if (condBit) begin
          if (atTop) seqFault = 1'b1;
          else       nextUpc = upcInc;
        end
      end
      default: nextUpc = upc;
    endcase
    if (seqFault) nextUpc = UADDR_W'(ERR_ADDR);
  end

  // Stack moves only on a normal sequencing step; an exception flushes it instead.
  assign advance = !rst && !stall;

  micro_stack #(
    .WIDTH (UADDR_W),
    .DEPTH (STACK_DEPTH)
  ) uStack (
    .clk   (clk),
    .rst   (rst),
    .push  (advance && !excAny && doPush),
    .pop   (advance && !excAny && doPop),
    .flush (advance && excAny),
    .din   (upcInc),
    .dout  (stackTop),
    .full  (stackFull),
    .empty (stackEmpty),
    .depth (stack_depth)
  );

  // Register microaddress and status flags with reset > stall > exception > decode priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      upc       <= '0;
      exc_taken <= 1'b0;
      exc_cause <= '0;
      seq_err   <= 1'b0;
    end else if (stall) begin
      exc_taken <= 1'b0;
    end else if (excAny) begin
      upc       <= UADDR_W'(EXC_BASE) + UADDR_W'(excIdx);
      exc_taken <= 1'b1;
      exc_cause <= excIdx;
    end else begin
      upc       <= nextUpc;
      exc_taken <= 1'b0;
      if (seqFault) seq_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: directed scenarios with literal expectations,
// then randomized stimulus, all checked every cycle against a queue-based model.
module tb_micro_sequencer;

  localparam int unsigned EXC_BASE = 28;
  localparam int unsigned ERR_ADDR = 31;
  localparam int unsigned MAXD     = 2;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [39:0] uinst;
  logic [14:0] dispatch_addr;
  logic [3:0]  cond;
  logic [1:0]  exc_req;
  logic [4:0]  upc;
  logic [29:0] ctrl;
  logic [2:0]  seq_op;
  logic [1:0]  stack_depth;
  logic        exc_taken;
  logic        exc_cause;
  logic        seq_err;

  logic [29:0] tCtrl;
  logic [2:0]  tOp;
  logic [1:0]  tCsel;
  logic [4:0]  tTgt;
  logic [4:0]  dispArr [3];

  assign uinst         = {tCtrl, tOp, tCsel, tTgt};
  assign dispatch_addr = {dispArr[2], dispArr[1], dispArr[0]};

  micro_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .uinst         (uinst),
    .dispatch_addr (dispatch_addr),
    .cond          (cond),
    .exc_req       (exc_req),
    .upc           (upc),
    .ctrl          (ctrl),
    .seq_op        (seq_op),
    .stack_depth   (stack_depth),
    .exc_taken     (exc_taken),
    .exc_cause     (exc_cause),
    .seq_err       (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state
  bit          modelValid = 0;
  int unsigned mUpc       = 0;
  int unsigned mStack[$];
  int unsigned mCause     = 0;
  bit          mTaken     = 0;
  bit          mErr       = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs presented this cycle.
  task automatic modelStep();
    int unsigned nxt;
    int unsigned idx;
    bit          err;
    bit          c;
    if (rst) begin
      mUpc = 0; mStack.delete(); mTaken = 0; mCause = 0; mErr = 0;
      return;
    end
    if (stall) begin
      mTaken = 0;
      return;
    end
    if (exc_req != 0) begin
      idx = exc_req[0] ? 0 : 1;
      mUpc = EXC_BASE + idx; mStack.delete(); mTaken = 1; mCause = idx;
      return;
    end
    mTaken = 0;
    err = 0;
    nxt = mUpc;
    c = cond[tCsel];
    case (tOp)
      3'd0: nxt = 0;
      3'd1: if (mUpc == 31) err = 1; else nxt = mUpc + 1;
      3'd2: begin
        idx = tTgt % 4;
        if (idx >= 3) err = 1; else nxt = dispArr[idx];
      end
      3'd3: nxt = tTgt;
      3'd4: if (c) nxt = tTgt; else if (mUpc == 31) err = 1; else nxt = mUpc + 1;
      3'd5: begin
        if (mStack.size() == MAXD) err = 1;
        else begin mStack.push_back((mUpc + 1) % 32); nxt = tTgt; end
      end
      3'd6: begin
        if (mStack.size() == 0) err = 1; else nxt = mStack.pop_back();
      end
      default: if (c) begin
        if (mUpc == 31) err = 1; else nxt = mUpc + 1;
      end
    endcase
    if (err) begin mErr = 1; nxt = ERR_ADDR; end
    mUpc = nxt;
  endtask

  task automatic cycle();
    @(posedge clk);
    modelStep();
    modelValid = 1;
    #1;
  endtask

  task automatic setUi(input logic [2:0] op, input logic [1:0] cs, input logic [4:0] tg);
    tOp = op; tCsel = cs; tTgt = tg; tCtrl = 30'($urandom());
  endtask

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (modelValid) begin
      chk("upc",         64'(upc),         64'(mUpc));
      chk("stack_depth", 64'(stack_depth), 64'(mStack.size()));
      chk("exc_taken",   64'(exc_taken),   64'(mTaken));
      chk("exc_cause",   64'(exc_cause),   64'(mCause));
      chk("seq_err",     64'(seq_err),     64'(mErr));
      chk("ctrl",        64'(ctrl),        (rst || stall) ? 64'd0 : 64'(tCtrl));
      chk("seq_op",      64'(seq_op),      64'(tOp));
    end
  end

  initial begin
    rst = 1; stall = 0; cond = '0; exc_req = '0;
    dispArr[0] = 5'd0; dispArr[1] = 5'd0; dispArr[2] = 5'd0;
    setUi(3'd1, 2'd0, 5'd0);
    tCtrl = 30'h1234567;

    // Reset, then sequential stepping
    cycle(); cycle();
    chk("rst_upc", 64'(upc), 64'd0);
    chk("rst_ctrl", 64'(ctrl), 64'd0);
    chk("rst_err", 64'(seq_err), 64'd0);
    rst = 0;
    cycle(); chk("next_1", 64'(upc), 64'd1);
    cycle(); chk("next_2", 64'(upc), 64'd2);

    // Dispatch
    dispArr[1] = 5'd13;
    setUi(3'd2, 2'd0, 5'd1); cycle(); chk("disp_13", 64'(upc), 64'd13);
    setUi(3'd2, 2'd0, 5'd3); cycle();
    chk("disp_bad_upc", 64'(upc), 64'd31);
    chk("disp_bad_err", 64'(seq_err), 64'd1);
    rst = 1; cycle(); rst = 0;

    // Conditional branch and wait
    cond = 4'b0100;
    setUi(3'd4, 2'd2, 5'd9); cycle(); chk("cbr_taken", 64'(upc), 64'd9);
    cond = 4'b0000; cycle(); chk("cbr_not", 64'(upc), 64'd10);
    setUi(3'd3, 2'd0, 5'd6); cycle();
    setUi(3'd7, 2'd2, 5'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(); chk("wait_hold", 64'(upc), 64'd6);
    end
    cond = 4'b0100; cycle(); chk("wait_done", 64'(upc), 64'd7);

    // Call / return
    setUi(3'd3, 2'd0, 5'd4); cycle();
    setUi(3'd5, 2'd0, 5'd20); cycle();
    chk("call1_upc", 64'(upc), 64'd20); chk("call1_depth", 64'(stack_depth), 64'd1);
    setUi(3'd5, 2'd0, 5'd24); cycle();
    chk("call2_depth", 64'(stack_depth), 64'd2);
    setUi(3'd6, 2'd0, 5'd0); cycle(); chk("ret1", 64'(upc), 64'd21);
    cycle(); chk("ret2", 64'(upc), 64'd5);
    setUi(3'd5, 2'd0, 5'd20); cycle();
    setUi(3'd5, 2'd0, 5'd24); cycle();
    setUi(3'd5, 2'd0, 5'd8);  cycle();
    chk("call_full_upc", 64'(upc), 64'd31);
    chk("call_full_err", 64'(seq_err), 64'd1);
    rst = 1; cycle(); rst = 0;

    // Exception during CALL
    setUi(3'd3, 2'd0, 5'd4);  cycle();
    setUi(3'd5, 2'd0, 5'd20); cycle();
    setUi(3'd5, 2'd0, 5'd24); exc_req = 2'b11; cycle();
    chk("exc_upc", 64'(upc), 64'd28);
    chk("exc_cause0", 64'(exc_cause), 64'd0);
    chk("exc_taken", 64'(exc_taken), 64'd1);
    chk("exc_depth", 64'(stack_depth), 64'd0);
    exc_req = 2'b00; setUi(3'd3, 2'd0, 5'd3); cycle();
    chk("exc_pulse_end", 64'(exc_taken), 64'd0);

    // Stall with a pending request
    setUi(3'd1, 2'd0, 5'd0); exc_req = 2'b10; stall = 1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("stall_upc", 64'(upc), 64'd3);
      chk("stall_ctrl", 64'(ctrl), 64'd0);
      chk("stall_taken", 64'(exc_taken), 64'd0);
    end
    stall = 0; cycle();
    chk("post_stall_upc", 64'(upc), 64'd29);
    chk("post_stall_cause", 64'(exc_cause), 64'd1);
    exc_req = 2'b00;

    // Randomized phase
    for (int n = 0; n < 3000; n++) begin
      setUi(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
      cond = 4'($urandom());
      for (int k = 0; k < 3; k++) dispArr[k] = 5'($urandom());
      rst   = ($urandom_range(0, 63) == 0);
      stall = ($urandom_range(0, 7) == 0);
      exc_req = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      cycle();
    end

    rst = 0; stall = 0; exc_req = '0;
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
